// File: rtl/ctrl_fsm_if.sv
// Control bundle between the instruction controller and the datapath.
// Latency: none; wires only.
// Backpressure: none; run is a level permit and is sampled by the controller.
//
// master: the controller. It reads run/inst/breq/brlt and drives the datapath
//         controls, status and the retired-instruction count.
// slave : the datapath side, with the directions mirrored.
interface ctrl_fsm_if #(
    parameter int INST_WIDTH = 32
);
    // datapath -> controller
    logic                  run;
    logic [INST_WIDTH-1:0] inst;
    logic                  breq;
    logic                  brlt;

    // controller -> datapath
    logic                  ena_pc;
    logic                  pcsel;
    logic                  brun;
    logic                  bsel;
    logic                  asel;
    logic                  memrw;
    logic [1:0]            regwen;
    logic [2:0]            immsel;
    logic [1:0]            wbsel;
    logic [3:0]            alusel;

    // status
    logic                  busy;
    logic [2:0]            state;
    logic [31:0]           instret;
    logic                  illegal;

    modport master (
        input  run, inst, breq, brlt,
        output ena_pc, pcsel, brun, bsel, asel, memrw,
        output regwen, immsel, wbsel, alusel,
        output busy, state, instret, illegal
    );

    modport slave (
        output run, inst, breq, brlt,
        input  ena_pc, pcsel, brun, bsel, asel, memrw,
        input  regwen, immsel, wbsel, alusel,
        input  busy, state, instret, illegal
    );
endinterface

// File: rtl/ctrl_fsm.sv
// Multi-cycle RV32I instruction controller: sequences FETCH/DECODE/EXEC[/MEM] and decodes datapath controls.
// Latency: 3 cycles (FETCH..EXEC) for non-memory ops, 4 cycles for load/store; controls are combinational on state+inst.
// Backpressure: none; run=0 holds the controller in IDLE, and an in-flight instruction always completes first.
//
// Ports:
//   clk   - single clock, rising edge
//   rst_  - asynchronous active-low reset; aborts any instruction with no write and no PC update
//   bus   - ctrl_fsm_if.master: run/inst/breq/brlt in; ena_pc, pcsel, brun, bsel, asel, memrw,
//           regwen[1:0], immsel[2:0], wbsel[1:0], alusel[3:0], busy, state[2:0], instret[31:0], illegal out
//
// Build option CTRL_FSM_ILLEGAL_TRAP_EN: when defined, an unrecognised opcode seen in DECODE parks the
// controller in TRAP with a sticky illegal flag until reset. When undefined, such an instruction runs as a
// 3-cycle NOP (PC+4, no writes, instret counts it), illegal is tied 0 and TRAP is unreachable.
module ctrl_fsm #(
    parameter int INST_WIDTH   = 32,
    parameter int OPCODE_WIDTH = 5
) (
    input  logic        clk,
    input  logic        rst_,
    ctrl_fsm_if.master  bus
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_TRAP   = 3'd5
    } state_t;

    // Major opcodes, inst[6:2]
    localparam logic [OPCODE_WIDTH-1:0] OPC_LOAD   = OPCODE_WIDTH'(5'b00000);
    localparam logic [OPCODE_WIDTH-1:0] OPC_OPIMM  = OPCODE_WIDTH'(5'b00100);
    localparam logic [OPCODE_WIDTH-1:0] OPC_AUIPC  = OPCODE_WIDTH'(5'b00101);
    localparam logic [OPCODE_WIDTH-1:0] OPC_STORE  = OPCODE_WIDTH'(5'b01000);
    localparam logic [OPCODE_WIDTH-1:0] OPC_OP     = OPCODE_WIDTH'(5'b01100);
    localparam logic [OPCODE_WIDTH-1:0] OPC_LUI    = OPCODE_WIDTH'(5'b01101);
    localparam logic [OPCODE_WIDTH-1:0] OPC_BRANCH = OPCODE_WIDTH'(5'b11000);
    localparam logic [OPCODE_WIDTH-1:0] OPC_JALR   = OPCODE_WIDTH'(5'b11001);
    localparam logic [OPCODE_WIDTH-1:0] OPC_JAL    = OPCODE_WIDTH'(5'b11011);

    localparam logic [2:0] IMM_I = 3'd0;
    localparam logic [2:0] IMM_S = 3'd1;
    localparam logic [2:0] IMM_B = 3'd2;
    localparam logic [2:0] IMM_U = 3'd3;
    localparam logic [2:0] IMM_J = 3'd4;

    localparam logic [1:0] WB_MEM = 2'b00;
    localparam logic [1:0] WB_ALU = 2'b01;
    localparam logic [1:0] WB_PC4 = 2'b10;

    localparam logic [3:0] ALU_ADD   = 4'd0;
    localparam logic [3:0] ALU_SUB   = 4'd1;
    localparam logic [3:0] ALU_SLL   = 4'd2;
    localparam logic [3:0] ALU_SLT   = 4'd3;
    localparam logic [3:0] ALU_SLTU  = 4'd4;
    localparam logic [3:0] ALU_XOR   = 4'd5;
    localparam logic [3:0] ALU_SRL   = 4'd6;
    localparam logic [3:0] ALU_SRA   = 4'd7;
    localparam logic [3:0] ALU_OR    = 4'd8;
    localparam logic [3:0] ALU_AND   = 4'd9;
    localparam logic [3:0] ALU_PASSB = 4'd10;

    state_t      cur_state;
    logic [31:0] instret_q;

    // ------------------------------------------------------------------
    // Instruction field decode
    // ------------------------------------------------------------------
    logic [OPCODE_WIDTH-1:0] opcode;
    logic [2:0]              funct3;
    logic                    alt;      // inst[30]: SUB / SRA selector
    logic                    quad_ok;  // 32-bit encoding (inst[1:0] == 11)

    assign opcode  = bus.inst[OPCODE_WIDTH+1:2];
    assign funct3  = bus.inst[14:12];
    assign alt     = bus.inst[30];
    assign quad_ok = (bus.inst[1:0] == 2'b11);

    // Register numbers and immediate bits are consumed by the datapath, not here.
    logic unused_inst_bits;
    assign unused_inst_bits = ^{bus.inst[INST_WIDTH-1:31], bus.inst[29:15], bus.inst[11:7]};

    logic is_load, is_store, is_branch, is_jalr, is_jal;
    logic is_opimm, is_op, is_auipc, is_lui;
    logic mem_op, writes_rd, br_taken;

    assign is_load   = quad_ok && (opcode == OPC_LOAD);
    assign is_store  = quad_ok && (opcode == OPC_STORE);
    assign is_branch = quad_ok && (opcode == OPC_BRANCH);
    assign is_jalr   = quad_ok && (opcode == OPC_JALR);
    assign is_jal    = quad_ok && (opcode == OPC_JAL);
    assign is_opimm  = quad_ok && (opcode == OPC_OPIMM);
    assign is_op     = quad_ok && (opcode == OPC_OP);
    assign is_auipc  = quad_ok && (opcode == OPC_AUIPC);
    assign is_lui    = quad_ok && (opcode == OPC_LUI);

    assign mem_op    = is_load || is_store;
    assign writes_rd = is_op || is_opimm || is_lui || is_auipc || is_jal || is_jalr || is_load;

`ifdef CTRL_FSM_ILLEGAL_TRAP_EN
    logic known;
    assign known = is_load || is_store || is_branch || is_jalr || is_jal ||
                   is_opimm || is_op || is_auipc || is_lui;
`endif

    // Branch resolution from the comparator flags; funct3 010/011 are not
    // branches and resolve as not-taken.
    always_comb begin
        br_taken = 1'b0;
        case (funct3)
            3'b000:  br_taken =  bus.breq;   // BEQ
            3'b001:  br_taken = !bus.breq;   // BNE
            3'b100:  br_taken =  bus.brlt;   // BLT
            3'b101:  br_taken = !bus.brlt;   // BGE
            3'b110:  br_taken =  bus.brlt;   // BLTU
            3'b111:  br_taken = !bus.brlt;   // BGEU
            default: br_taken = 1'b0;
        endcase
    end

    // OP and OP-IMM share the funct3 map; inst[30] means SUB only for OP
    // (for ADDI it is an immediate bit), but it selects SRA for both.
    function automatic logic [3:0] alu_decode(input logic [2:0] f3, input logic a30, input logic reg_form);
        logic [3:0] sel;
        sel = ALU_ADD;
        case (f3)
            3'b000:  sel = (a30 && reg_form) ? ALU_SUB : ALU_ADD;
            3'b001:  sel = ALU_SLL;
            3'b010:  sel = ALU_SLT;
            3'b011:  sel = ALU_SLTU;
            3'b100:  sel = ALU_XOR;
            3'b101:  sel = a30 ? ALU_SRA : ALU_SRL;
            3'b110:  sel = ALU_OR;
            default: sel = ALU_AND;
        endcase
        return sel;
    endfunction

    // ------------------------------------------------------------------
    // Control outputs: decode of registered state plus the current inst.
    // IDLE and TRAP drive everything to 0, so reset clears the controls
    // the moment the state register is forced to IDLE.
    // ------------------------------------------------------------------
    logic       ena_pc_w;
    logic       active;
    logic       final_cyc;

    assign active = (cur_state == S_FETCH) || (cur_state == S_DECODE) ||
                    (cur_state == S_EXEC)  || (cur_state == S_MEM);

    // MEM is only entered for load/store, so it is always the final cycle.
    assign final_cyc = ((cur_state == S_EXEC) && !mem_op) || (cur_state == S_MEM);
    assign ena_pc_w  = final_cyc;

    always_comb begin
        bus.pcsel  = 1'b0;
        bus.brun   = 1'b0;
        bus.bsel   = 1'b0;
        bus.asel   = 1'b0;
        bus.memrw  = 1'b0;
        bus.regwen = 2'b00;
        bus.immsel = IMM_I;
        bus.wbsel  = 2'b00;
        bus.alusel = ALU_ADD;

        if (active) begin
            if (is_store)                bus.immsel = IMM_S;
            else if (is_branch)          bus.immsel = IMM_B;
            else if (is_lui || is_auipc) bus.immsel = IMM_U;
            else if (is_jal)             bus.immsel = IMM_J;
            else                         bus.immsel = IMM_I;

            if (is_load)                 bus.wbsel = WB_MEM;
            else if (is_jal || is_jalr)  bus.wbsel = WB_PC4;
            else                         bus.wbsel = WB_ALU;

            if (is_op || is_opimm)       bus.alusel = alu_decode(funct3, alt, is_op);
            else if (is_lui)             bus.alusel = ALU_PASSB;
            else                         bus.alusel = ALU_ADD;

            bus.asel = is_auipc || is_jal || is_branch;
            bus.bsel = !is_op;
            bus.brun = is_branch && funct3[1];

            bus.regwen = {1'b0, final_cyc && writes_rd};
            bus.memrw  = (cur_state == S_MEM) && is_store;
            bus.pcsel  = (cur_state == S_EXEC) &&
                         (is_jal || is_jalr || (is_branch && br_taken));
        end
    end

    assign bus.ena_pc  = ena_pc_w;
    assign bus.busy    = active;
    assign bus.state   = cur_state;
    assign bus.instret = instret_q;

    // ------------------------------------------------------------------
    // State register, retired-instruction counter, illegal flag
    // ------------------------------------------------------------------
`ifdef CTRL_FSM_ILLEGAL_TRAP_EN
    logic illegal_q;
    assign bus.illegal = illegal_q;
`else
    assign bus.illegal = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            cur_state <= S_IDLE;
            instret_q <= 32'd0;
`ifdef CTRL_FSM_ILLEGAL_TRAP_EN
            illegal_q <= 1'b0;
`endif
        end else begin
            // Wraps 0xFFFFFFFF -> 0 by natural overflow.
            if (ena_pc_w) begin
                instret_q <= instret_q + 32'd1;
            end

            case (cur_state)
                S_IDLE: begin
                    if (bus.run) cur_state <= S_FETCH;
                end
                S_FETCH: begin
                    cur_state <= S_DECODE;
                end
                S_DECODE: begin
`ifdef CTRL_FSM_ILLEGAL_TRAP_EN
                    if (!known) begin
                        cur_state <= S_TRAP;
                        illegal_q <= 1'b1;
                    end else begin
                        cur_state <= S_EXEC;
                    end
`else
                    cur_state <= S_EXEC;
`endif
                end
                S_EXEC: begin
                    if (mem_op)       cur_state <= S_MEM;
                    else if (bus.run) cur_state <= S_FETCH;
                    else              cur_state <= S_IDLE;
                end
                S_MEM: begin
                    cur_state <= bus.run ? S_FETCH : S_IDLE;
                end
                S_TRAP: begin
                    // Only reset leaves TRAP.
                    cur_state <= S_TRAP;
                end
                default: begin
                    cur_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ctrl_fsm.sv
// Directed bench for ctrl_fsm: a vector table of single instructions plus hand sequences for reset, run drop and illegal opcodes.
// Latency: each vector is stepped cycle by cycle from FETCH to its final state.
// Backpressure: none; run is held high except in the run-drop sequences.
module tb_ctrl_fsm;

    logic clk;
    logic rst_;

    ctrl_fsm_if #(.INST_WIDTH(32)) bus ();

    ctrl_fsm #(.INST_WIDTH(32), .OPCODE_WIDTH(5)) dut (
        .clk  (clk),
        .rst_ (rst_),
        .bus  (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // care bits select which decode fields a vector constrains
    localparam logic [5:0] C_IMM  = 6'b000001;
    localparam logic [5:0] C_WB   = 6'b000010;
    localparam logic [5:0] C_ALU  = 6'b000100;
    localparam logic [5:0] C_ASEL = 6'b001000;
    localparam logic [5:0] C_BSEL = 6'b010000;
    localparam logic [5:0] C_BRUN = 6'b100000;

    typedef struct packed {
        logic [31:0] inst;
        logic        breq;
        logic        brlt;
        logic [2:0]  cycles;
        logic [1:0]  regwen;
        logic        memrw;
        logic        pcsel;
        logic        asel;
        logic        bsel;
        logic        brun;
        logic [2:0]  immsel;
        logic [1:0]  wbsel;
        logic [3:0]  alusel;
        logic [5:0]  care;
    } vec_t;

    localparam int NV = 17;
    vec_t vecs [NV];

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] exp_instret = 32'd0;

    localparam logic [31:0] I_ADDI = 32'h00500093;
    localparam logic [31:0] I_LW   = 32'h0000A103;
    localparam logic [31:0] I_SW   = 32'h00112023;
    localparam logic [31:0] I_BAD  = 32'hFFFFFFFF;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [31:0] inst, input logic breq, input logic brlt,
                                input int cycles, input logic [1:0] regwen, input logic memrw,
                                input logic pcsel, input logic asel, input logic bsel, input logic brun,
                                input logic [2:0] immsel, input logic [1:0] wbsel,
                                input logic [3:0] alusel, input logic [5:0] care);
        vec_t v;
        v.inst = inst;    v.breq = breq;   v.brlt = brlt;   v.cycles = 3'(cycles);
        v.regwen = regwen; v.memrw = memrw; v.pcsel = pcsel; v.asel = asel;
        v.bsel = bsel;    v.brun = brun;   v.immsel = immsel; v.wbsel = wbsel;
        v.alusel = alusel; v.care = care;
        return v;
    endfunction

    function automatic logic [16:0] ctrl_bits();
        return {bus.ena_pc, bus.pcsel, bus.brun, bus.bsel, bus.asel, bus.memrw,
                bus.regwen, bus.immsel, bus.wbsel, bus.alusel};
    endfunction

    // Entered at a negedge with state == FETCH; leaves at the negedge after
    // the final cycle (state back in FETCH since run stays high).
    task automatic run_vec(input int id, input vec_t v);
        bus.inst = v.inst;
        bus.breq = v.breq;
        bus.brlt = v.brlt;
        #1;
        for (int cyc = 1; cyc <= int'(v.cycles); cyc++) begin
            if (cyc > 1) @(negedge clk);
            chk($sformatf("v%0d state c%0d", id, cyc), 32'(bus.state), 32'(cyc));
            chk($sformatf("v%0d busy c%0d", id, cyc), 32'(bus.busy), 32'd1);
            if (cyc == int'(v.cycles)) begin
                chk($sformatf("v%0d ena_pc final", id), 32'(bus.ena_pc), 32'd1);
                chk($sformatf("v%0d regwen final", id), 32'(bus.regwen), 32'(v.regwen));
                chk($sformatf("v%0d memrw final", id), 32'(bus.memrw), 32'(v.memrw));
                if (v.care & C_IMM)  chk($sformatf("v%0d immsel", id), 32'(bus.immsel), 32'(v.immsel));
                if (v.care & C_WB)   chk($sformatf("v%0d wbsel", id), 32'(bus.wbsel), 32'(v.wbsel));
                if (v.care & C_ALU)  chk($sformatf("v%0d alusel", id), 32'(bus.alusel), 32'(v.alusel));
                if (v.care & C_ASEL) chk($sformatf("v%0d asel", id), 32'(bus.asel), 32'(v.asel));
                if (v.care & C_BSEL) chk($sformatf("v%0d bsel", id), 32'(bus.bsel), 32'(v.bsel));
                if (v.care & C_BRUN) chk($sformatf("v%0d brun", id), 32'(bus.brun), 32'(v.brun));
            end else begin
                chk($sformatf("v%0d ena_pc c%0d", id, cyc), 32'(bus.ena_pc), 32'd0);
                chk($sformatf("v%0d regwen c%0d", id, cyc), 32'(bus.regwen), 32'd0);
                chk($sformatf("v%0d memrw c%0d", id, cyc), 32'(bus.memrw), 32'd0);
            end
            if (cyc == 3) chk($sformatf("v%0d pcsel exec", id), 32'(bus.pcsel), 32'(v.pcsel));
        end
        @(negedge clk);
        exp_instret = exp_instret + 32'd1;
        chk($sformatf("v%0d instret", id), bus.instret, exp_instret);
        chk($sformatf("v%0d next state", id), 32'(bus.state), 32'd1);
    endtask

    initial begin
        //            inst          beq brl cyc rw  mrw pcs asl bsl brn imm   wb     alu    care
        vecs[0]  = mk(I_ADDI,       0,  0,  3,  1,  0,  0,  0,  1,  0,  3'd0, 2'b01, 4'd0,  C_IMM|C_WB|C_ALU|C_ASEL|C_BSEL);
        vecs[1]  = mk(32'h00208463, 1,  0,  3,  0,  0,  1,  1,  1,  0,  3'd2, 2'b00, 4'd0,  C_IMM|C_ALU|C_ASEL|C_BSEL|C_BRUN);
        vecs[2]  = mk(32'h00208463, 0,  1,  3,  0,  0,  0,  1,  1,  0,  3'd2, 2'b00, 4'd0,  C_IMM|C_ALU|C_ASEL|C_BSEL|C_BRUN);
        vecs[3]  = mk(32'h00209463, 0,  0,  3,  0,  0,  1,  1,  1,  0,  3'd2, 2'b00, 4'd0,  C_IMM|C_ASEL|C_BRUN);
        vecs[4]  = mk(32'h0020E463, 0,  1,  3,  0,  0,  1,  1,  1,  1,  3'd2, 2'b00, 4'd0,  C_IMM|C_ASEL|C_BRUN);
        vecs[5]  = mk(32'h0020D463, 1,  1,  3,  0,  0,  0,  1,  1,  0,  3'd2, 2'b00, 4'd0,  C_IMM|C_ASEL|C_BRUN);
        vecs[6]  = mk(I_LW,         0,  0,  4,  1,  0,  0,  0,  1,  0,  3'd0, 2'b00, 4'd0,  C_IMM|C_WB|C_ALU|C_ASEL|C_BSEL);
        vecs[7]  = mk(I_SW,         0,  0,  4,  0,  1,  0,  0,  1,  0,  3'd1, 2'b00, 4'd0,  C_IMM|C_ALU|C_ASEL|C_BSEL);
        vecs[8]  = mk(32'h402081B3, 0,  0,  3,  1,  0,  0,  0,  0,  0,  3'd0, 2'b01, 4'd1,  C_WB|C_ALU|C_ASEL|C_BSEL);
        vecs[9]  = mk(32'h4030D093, 0,  0,  3,  1,  0,  0,  0,  1,  0,  3'd0, 2'b01, 4'd7,  C_IMM|C_WB|C_ALU|C_BSEL);
        vecs[10] = mk(32'h40000093, 0,  0,  3,  1,  0,  0,  0,  1,  0,  3'd0, 2'b01, 4'd0,  C_IMM|C_WB|C_ALU|C_BSEL);
        vecs[11] = mk(32'h0020F1B3, 0,  0,  3,  1,  0,  0,  0,  0,  0,  3'd0, 2'b01, 4'd9,  C_WB|C_ALU|C_BSEL);
        vecs[12] = mk(32'h123452B7, 0,  0,  3,  1,  0,  0,  0,  1,  0,  3'd3, 2'b01, 4'd10, C_IMM|C_WB|C_ALU|C_ASEL|C_BSEL);
        vecs[13] = mk(32'h00001297, 0,  0,  3,  1,  0,  0,  1,  1,  0,  3'd3, 2'b01, 4'd0,  C_IMM|C_WB|C_ALU|C_ASEL|C_BSEL);
        vecs[14] = mk(32'h008000EF, 0,  0,  3,  1,  0,  1,  1,  1,  0,  3'd4, 2'b10, 4'd0,  C_IMM|C_WB|C_ALU|C_ASEL|C_BSEL);
        vecs[15] = mk(32'h000100E7, 0,  0,  3,  1,  0,  1,  0,  1,  0,  3'd0, 2'b10, 4'd0,  C_IMM|C_WB|C_ALU|C_ASEL|C_BSEL);
        vecs[16] = mk(32'h0010B093, 0,  0,  3,  1,  0,  0,  0,  1,  0,  3'd0, 2'b01, 4'd4,  C_IMM|C_WB|C_ALU|C_BSEL);

        bus.run  = 1'b1;
        bus.inst = 32'd0;
        bus.breq = 1'b0;
        bus.brlt = 1'b0;
        rst_     = 1'b1;
        #1 rst_  = 1'b0;

        // Reset state, held across a clock edge with run=1
        @(negedge clk);
        chk("rst state", 32'(bus.state), 32'd0);
        chk("rst instret", bus.instret, 32'd0);
        chk("rst illegal", 32'(bus.illegal), 32'd0);
        chk("rst busy", 32'(bus.busy), 32'd0);
        chk("rst controls", 32'(ctrl_bits()), 32'd0);
        @(negedge clk);
        chk("rst hold state", 32'(bus.state), 32'd0);
        rst_ = 1'b1;
        #1;
        chk("rst release state", 32'(bus.state), 32'd0);
        @(negedge clk);

        for (int i = 0; i < NV; i++) begin
            run_vec(i, vecs[i]);
        end

        // run drops during DECODE: ADDI still completes, then IDLE
        bus.inst = I_ADDI;
        @(negedge clk);
        chk("drop decode state", 32'(bus.state), 32'd2);
        bus.run = 1'b0;
        @(negedge clk);
        chk("drop exec state", 32'(bus.state), 32'd3);
        chk("drop exec ena_pc", 32'(bus.ena_pc), 32'd1);
        chk("drop exec regwen", 32'(bus.regwen), 32'd1);
        @(negedge clk);
        exp_instret = exp_instret + 32'd1;
        chk("drop idle state", 32'(bus.state), 32'd0);
        chk("drop idle busy", 32'(bus.busy), 32'd0);
        chk("drop instret", bus.instret, exp_instret);
        @(negedge clk);
        chk("drop idle hold", 32'(bus.state), 32'd0);
        bus.run = 1'b1;
        @(negedge clk);
        chk("drop restart", 32'(bus.state), 32'd1);

        // run drops during EXEC of a load: MEM completes, then IDLE
        bus.inst = I_LW;
        @(negedge clk);
        @(negedge clk);
        chk("ld drop exec state", 32'(bus.state), 32'd3);
        chk("ld drop exec ena_pc", 32'(bus.ena_pc), 32'd0);
        bus.run = 1'b0;
        @(negedge clk);
        chk("ld drop mem state", 32'(bus.state), 32'd4);
        chk("ld drop mem ena_pc", 32'(bus.ena_pc), 32'd1);
        chk("ld drop mem regwen", 32'(bus.regwen), 32'd1);
        @(negedge clk);
        exp_instret = exp_instret + 32'd1;
        chk("ld drop idle", 32'(bus.state), 32'd0);
        chk("ld drop instret", bus.instret, exp_instret);
        bus.run = 1'b1;
        @(negedge clk);
        chk("ld drop restart", 32'(bus.state), 32'd1);

        // Reset asserted during EXEC of a store
        bus.inst = I_SW;
        @(negedge clk);
        @(negedge clk);
        chk("sw rst exec state", 32'(bus.state), 32'd3);
        rst_ = 1'b0;
        #1;
        exp_instret = 32'd0;
        chk("sw rst state", 32'(bus.state), 32'd0);
        chk("sw rst memrw", 32'(bus.memrw), 32'd0);
        chk("sw rst instret", bus.instret, exp_instret);
        chk("sw rst controls", 32'(ctrl_bits()), 32'd0);
        @(negedge clk);
        chk("sw rst hold state", 32'(bus.state), 32'd0);
        chk("sw rst hold memrw", 32'(bus.memrw), 32'd0);
        rst_ = 1'b1;
        #1;
        chk("sw rst release state", 32'(bus.state), 32'd0);
        @(negedge clk);
        chk("sw rst restart", 32'(bus.state), 32'd1);
        chk("sw rst restart instret", bus.instret, exp_instret);

        // Unrecognised opcode
`ifdef CTRL_FSM_ILLEGAL_TRAP_EN
        bus.inst = I_BAD;
        @(negedge clk);
        chk("trap decode state", 32'(bus.state), 32'd2);
        @(negedge clk);
        chk("trap state", 32'(bus.state), 32'd5);
        chk("trap illegal", 32'(bus.illegal), 32'd1);
        chk("trap busy", 32'(bus.busy), 32'd0);
        chk("trap ena_pc", 32'(bus.ena_pc), 32'd0);
        chk("trap controls", 32'(ctrl_bits()), 32'd0);
        @(negedge clk);
        chk("trap hold state", 32'(bus.state), 32'd5);
        chk("trap hold instret", bus.instret, exp_instret);
        rst_ = 1'b0;
        #1;
        chk("trap rst state", 32'(bus.state), 32'd0);
        chk("trap rst illegal", 32'(bus.illegal), 32'd0);
        rst_ = 1'b1;
`else
        run_vec(NV, mk(I_BAD, 0, 0, 3, 0, 0, 0, 0, 0, 0, 3'd0, 2'b00, 4'd0, 6'b000000));
        chk("nop illegal", 32'(bus.illegal), 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
